// File: rtl/mmc3_chrram_core_pkg.sv
// Shared definitions for the MMC3-class bank controller.
// Holds the register-decode keys ({cpu_addr[14:13], cpu_addr[0]}), the
// indices of the PRG bank registers, the power-on bank register contents
// and a constant-evaluable clog2 helper used to size counters and slices.
package mmc3_chrram_core_pkg;

  // Register decode key = {cpu_addr[14:13], cpu_addr[0]}
  localparam logic [2:0] REG_BANK_SEL    = 3'b000;  // $8000
  localparam logic [2:0] REG_BANK_DATA   = 3'b001;  // $8001
  localparam logic [2:0] REG_MIRROR      = 3'b010;  // $A000
  localparam logic [2:0] REG_PRG_RAM     = 3'b011;  // $A001 (no effect)
  localparam logic [2:0] REG_IRQ_LATCH   = 3'b100;  // $C000
  localparam logic [2:0] REG_IRQ_RELOAD  = 3'b101;  // $C001
  localparam logic [2:0] REG_IRQ_DISABLE = 3'b110;  // $E000
  localparam logic [2:0] REG_IRQ_ENABLE  = 3'b111;  // $E001

  // Bank registers that feed the PRG map
  localparam int BANK_R6 = 6;
  localparam int BANK_R7 = 7;

  // Reset contents of R7..R0 (element [7] is the leftmost entry)
  localparam logic [7:0][7:0] RESET_BANKS = {
    8'd1, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4, 8'd2, 8'd0
  };

  // Smallest r with (1 << r) >= value
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mmc3_a12_filter.sv
// PPU A12 rising-edge qualifier for the scanline counter.
// A rising edge of a12 only counts when a12 has been sampled low for at
// least A12_LOW_MIN consecutive clocks, which rejects the short A12 toggles
// that occur inside one scanline's fetch pattern.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   a12         ppu_addr[12], synchronous to clk
//   a12_tick    combinational: high in the cycle a qualified edge is visible
module mmc3_a12_filter
  import mmc3_chrram_core_pkg::*;
#(
  parameter int A12_LOW_MIN = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a12,
  output logic a12_tick
);

  localparam int LW_RAW = clog2(A12_LOW_MIN + 1);
  localparam int LW     = (LW_RAW < 1) ? 1 : LW_RAW;
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_MIN);

  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic          a12_prev_q, a12_prev_d;

  always_comb begin
    low_cnt_d  = low_cnt_q;
    a12_prev_d = a12;
    if (a12) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + LW'(1);
    end
    // low_cnt_q still holds the low-run length that preceded this high sample
    a12_tick = a12 & ~a12_prev_q & (low_cnt_q == LOW_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q  <= '0;
      a12_prev_q <= 1'b0;
    end else begin
      low_cnt_q  <= low_cnt_d;
      a12_prev_q <= a12_prev_d;
    end
  end

endmodule

// File: rtl/mmc3_chrram_core.sv
// MMC3-class PRG/CHR bank controller with a runtime-sized CHR-RAM window
// and a filtered A12 scanline IRQ counter.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   cpu_addr/data/rw/m2       CPU bus; a write commits on the falling M2
//                             sample with rw=0 and cpu_addr[15]=1
//   ppu_addr                  PPU address
//   mir_h                     mirroring value adopted at reset release
//   ram_cnt                   number of 1K CHR-RAM banks (0 = off, clamped)
//   irq_alt                   1 selects the old-revision IRQ rule
//   prg_ce, prg_addr          PRG chip enable and 8K bank number
//   chr_addr, chr_ram_ce      CHR 1K bank number / RAM window hit
//   ciram_a10                 nametable A10
//   irq                       active-high, sticky until $E000 or reset
module mmc3_chrram_core
  import mmc3_chrram_core_pkg::*;
#(
  parameter int PRG_W       = 19,
  parameter int CHR_W       = 18,
  parameter int RAM_BASE    = 8,
  parameter int RAM_MAX     = 4,
  parameter int A12_LOW_MIN = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        cpu_addr,
  input  logic [7:0]         cpu_data,
  input  logic               cpu_rw,
  input  logic               cpu_m2,
  input  logic [13:0]        ppu_addr,
  input  logic               mir_h,
  input  logic [3:0]         ram_cnt,
  input  logic               irq_alt,
  output logic               prg_ce,
  output logic [PRG_W-14:0]  prg_addr,
  output logic [CHR_W-11:0]  chr_addr,
  output logic               chr_ram_ce,
  output logic               ciram_a10,
  output logic               irq
);

  localparam int PB     = PRG_W - 13;
  localparam int CB     = CHR_W - 10;
  localparam int RB     = clog2(RAM_MAX);
  localparam int RBW    = (RB < 1) ? 1 : RB;
  localparam logic [3:0] RAM_MAX_N  = 4'(RAM_MAX);
  localparam logic [9:0] RAM_BASE_W = 10'(RAM_BASE);

  // ---------------- register state ----------------
  logic             m2_prev_q, m2_prev_d;
  logic             init_q, init_d;      // first clock after reset release
  logic [2:0]       bank_sel_q, bank_sel_d;
  logic             prg_mode_q, prg_mode_d;
  logic             chr_inv_q, chr_inv_d;
  logic             mir_q, mir_d;
  logic [7:0][7:0]  r_q, r_d;
  logic [7:0]       latch_q, latch_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             reload_q, reload_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;

  logic             commit;
  logic [2:0]       reg_key;
  logic             mir_eff;
  logic             a12_tick;
  logic [7:0]       cnt_pre;
  logic             reload_pre;
  logic             irq_set;

  mmc3_a12_filter #(
    .A12_LOW_MIN(A12_LOW_MIN)
  ) u_a12_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .a12      (ppu_addr[12]),
    .a12_tick (a12_tick)
  );

  assign commit  = m2_prev_q & ~cpu_m2 & ~cpu_rw & cpu_addr[15];
  assign reg_key = {cpu_addr[14:13], cpu_addr[0]};
  // mir_h is followed until the first clock after reset, where it is latched
  assign mir_eff = init_q ? mir_h : mir_q;

  always_comb begin
    m2_prev_d  = cpu_m2;
    init_d     = 1'b0;
    bank_sel_d = bank_sel_q;
    prg_mode_d = prg_mode_q;
    chr_inv_d  = chr_inv_q;
    mir_d      = mir_eff;
    r_d        = r_q;
    latch_d    = latch_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;
    cnt_pre    = '0;
    reload_pre = 1'b0;
    irq_set    = 1'b0;

    // Register write first, so the edge logic below sees post-write values
    if (commit) begin
      case (reg_key)
        REG_BANK_SEL: begin
          bank_sel_d = cpu_data[2:0];
          prg_mode_d = cpu_data[6];
          chr_inv_d  = cpu_data[7];
        end
        REG_BANK_DATA:   r_d[bank_sel_q] = cpu_data;
        REG_MIRROR:      mir_d = cpu_data[0];
        REG_IRQ_LATCH:   latch_d = cpu_data;
        REG_IRQ_RELOAD: begin
          cnt_d    = '0;
          reload_d = 1'b1;
        end
        REG_IRQ_DISABLE: begin
          irq_en_d = 1'b0;
          irq_d    = 1'b0;
        end
        REG_IRQ_ENABLE:  irq_en_d = 1'b1;
        default: ;
      endcase
    end

    if (a12_tick) begin
      cnt_pre    = cnt_d;
      reload_pre = reload_d;
      if (cnt_d == 8'd0 || reload_d) begin
        cnt_d    = latch_d;
        reload_d = 1'b0;
      end else begin
        cnt_d = cnt_d - 8'd1;
      end
      // A $E000 in this cycle already cleared irq_en_d, so it wins here
      irq_set = irq_en_d && (cnt_d == 8'd0) &&
                (!irq_alt || (cnt_pre != 8'd0) || reload_pre);
      if (irq_set) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_prev_q  <= 1'b0;
      init_q     <= 1'b1;
      bank_sel_q <= '0;
      prg_mode_q <= 1'b0;
      chr_inv_q  <= 1'b0;
      mir_q      <= 1'b0;
      r_q        <= RESET_BANKS;
      latch_q    <= '0;
      cnt_q      <= '0;
      reload_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      m2_prev_q  <= m2_prev_d;
      init_q     <= init_d;
      bank_sel_q <= bank_sel_d;
      prg_mode_q <= prg_mode_d;
      chr_inv_q  <= chr_inv_d;
      mir_q      <= mir_d;
      r_q        <= r_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  // ---------------- PRG map ----------------
  logic [PB-1:0] prg_last, prg_r6, prg_r7;

  always_comb begin
    prg_last = '1;
    prg_r6   = PB'(r_q[BANK_R6]);
    prg_r7   = PB'(r_q[BANK_R7]);
    case (cpu_addr[14:13])
      2'd0:    prg_addr = prg_mode_q ? (prg_last - PB'(1)) : prg_r6;
      2'd1:    prg_addr = prg_r7;
      2'd2:    prg_addr = prg_mode_q ? prg_r6 : (prg_last - PB'(1));
      default: prg_addr = prg_last;
    endcase
  end

  assign prg_ce = cpu_addr[15];

  // ---------------- CHR map and RAM window ----------------
  logic [2:0]     chr_sel;
  logic [7:0]     chr_bank;
  logic [3:0]     ram_n;
  logic [3:0]     ram_mask;
  logic [9:0]     bank_ext;
  logic [RBW-1:0] ram_off;

  always_comb begin
    chr_sel = ppu_addr[12:10] ^ {chr_inv_q, 2'b00};
    case (chr_sel)
      3'd0, 3'd1: chr_bank = {r_q[0][7:1], chr_sel[0]};
      3'd2, 3'd3: chr_bank = {r_q[1][7:1], chr_sel[0]};
      default:    chr_bank = r_q[chr_sel - 3'd2];
    endcase

    ram_n      = (ram_cnt > RAM_MAX_N) ? RAM_MAX_N : ram_cnt;
    ram_mask   = ram_n - 4'd1;
    bank_ext   = {2'b00, chr_bank};
    chr_ram_ce = (ram_n != 4'd0) && !ppu_addr[13] &&
                 (bank_ext >= RAM_BASE_W) &&
                 (bank_ext < (RAM_BASE_W + {6'b0, ram_n}));
    ram_off    = ppu_addr[10 +: RBW] & ram_mask[RBW-1:0];
    chr_addr   = chr_ram_ce ? CB'(ram_off) : CB'(chr_bank);
  end

  assign ciram_a10 = mir_eff ? ppu_addr[11] : ppu_addr[10];
  assign irq       = irq_q;

  // Address bits and register bits that no mapping path consumes
  logic unused_ok;
  assign unused_ok = ^{cpu_addr[12:1], ppu_addr[9:0], r_q[0][0], r_q[1][0],
                       r_q[BANK_R6], r_q[BANK_R7], ram_mask, chr_bank};

endmodule

// File: tb/tb_mmc3_chrram_core.sv
// Directed bench for mmc3_chrram_core with a queue scoreboard: drivers push
// expected values, a negedge monitor pops and compares against the DUT.
module tb_mmc3_chrram_core;

  localparam int W = 8;
  localparam int T_PRG = 0, T_CHR = 1, T_CE = 2, T_IRQ = 3, T_A10 = 4, T_PCE = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_rw = 1'b1;
  logic        cpu_m2 = 1'b0;
  logic [13:0] ppu_addr = '0;
  logic        mir_h = 1'b1;
  logic [3:0]  ram_cnt = '0;
  logic        irq_alt = 1'b0;
  logic        prg_ce;
  logic [5:0]  prg_addr;
  logic [7:0]  chr_addr;
  logic        chr_ram_ce;
  logic        ciram_a10;
  logic        irq;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mmc3_chrram_core #(
    .PRG_W(19), .CHR_W(18), .RAM_BASE(8), .RAM_MAX(4), .A12_LOW_MIN(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .cpu_m2(cpu_m2), .ppu_addr(ppu_addr), .mir_h(mir_h),
    .ram_cnt(ram_cnt), .irq_alt(irq_alt), .prg_ce(prg_ce), .prg_addr(prg_addr),
    .chr_addr(chr_addr), .chr_ram_ce(chr_ram_ce), .ciram_a10(ciram_a10), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  string        name_q[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] mon_exp, mon_got;
  int           mon_tag;
  string        mon_name;

  function automatic logic [W-1:0] observe(input int tag);
    case (tag)
      T_PRG:   return W'(prg_addr);
      T_CHR:   return chr_addr;
      T_CE:    return W'(chr_ram_ce);
      T_IRQ:   return W'(irq);
      T_A10:   return W'(ciram_a10);
      default: return W'(prg_ce);
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_tag  = tag_q.pop_front();
      mon_name = name_q.pop_front();
      mon_got  = observe(mon_tag);
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", mon_name, mon_got, mon_exp);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input int tag, input logic [W-1:0] value, input string name);
    exp_q.push_back(value);
    tag_q.push_back(tag);
    name_q.push_back(name);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    step();
    cpu_addr = a; cpu_data = d; cpu_rw = 1'b0; cpu_m2 = 1'b1;
    step();
    cpu_m2 = 1'b0;
    step();
    cpu_rw = 1'b1;
  endtask

  // A12 low for low_cycles sampled clocks, then high; returns after the
  // clock that samples the high level.
  task automatic a12_edge(input int low_cycles);
    step();
    ppu_addr[12] = 1'b0;
    repeat (low_cycles) step();
    ppu_addr[12] = 1'b1;
    step();
  endtask

  task automatic check_prg(input logic [15:0] a, input logic [W-1:0] e, input string n);
    step();
    cpu_addr = a;
    expect_out(T_PRG, e, n);
    settle();
  endtask

  task automatic check_chr(input logic [13:0] p, input logic [W-1:0] e_addr,
                           input logic e_ce, input string n);
    step();
    ppu_addr = p;
    expect_out(T_CHR, e_addr, n);
    expect_out(T_CE, W'(e_ce), n);
    settle();
  endtask

  task automatic check_a10(input logic [13:0] p, input logic e, input string n);
    step();
    ppu_addr = p;
    expect_out(T_A10, W'(e), n);
    settle();
  endtask

  task automatic check_irq(input logic e, input string n);
    expect_out(T_IRQ, W'(e), n);
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_irq(1'b0, "irq_in_reset");
    step();
    rst_n = 1'b1;

    // Reset bank values and PRG map, mode 0
    check_prg(16'hE000, 8'h3F, "prg_last");
    check_prg(16'h8000, 8'h00, "prg_slot0_r6");
    check_prg(16'hA000, 8'h01, "prg_slot1_r7");
    check_prg(16'hC000, 8'h3E, "prg_slot2_last_m1");
    step(); cpu_addr = 16'h8000; expect_out(T_PCE, 8'h01, "prg_ce_hi"); settle();
    step(); cpu_addr = 16'h6000; expect_out(T_PCE, 8'h00, "prg_ce_lo"); settle();

    // Reset CHR map, window off
    check_chr(14'h1C00, 8'h07, 1'b0, "chr_s7_r5");
    check_chr(14'h0400, 8'h01, 1'b0, "chr_s1_r0_odd");
    check_chr(14'h0800, 8'h02, 1'b0, "chr_s2_r1");
    check_chr(14'h1000, 8'h04, 1'b0, "chr_s4_r2");

    // Mirroring from mir_h=1, then $A000 write
    check_a10(14'h0800, 1'b1, "a10_mir1_b11");
    check_a10(14'h0400, 1'b0, "a10_mir1_b10");
    cpu_write(16'hA000, 8'h00);
    check_a10(14'h0800, 1'b0, "a10_mir0_b11");
    check_a10(14'h0400, 1'b1, "a10_mir0_b10");

    // RAM window
    cpu_write(16'h8000, 8'h02);
    cpu_write(16'h8001, 8'h09);
    ram_cnt = 4'd4;
    check_chr(14'h1000, 8'h00, 1'b1, "win4_hit");
    check_chr(14'h3000, 8'h09, 1'b0, "win4_nametable");
    ram_cnt = 4'd1;
    check_chr(14'h1000, 8'h09, 1'b0, "win1_miss");
    ram_cnt = 4'd0;
    check_chr(14'h1000, 8'h09, 1'b0, "win0_off");
    ram_cnt = 4'd15;
    cpu_write(16'h8001, 8'h0C);
    check_chr(14'h1000, 8'h0C, 1'b0, "win_clamp_above");
    cpu_write(16'h8001, 8'h0B);
    check_chr(14'h1000, 8'h00, 1'b1, "win_clamp_top");
    cpu_write(16'h8000, 8'h01);
    cpu_write(16'h8001, 8'h08);
    ram_cnt = 4'd2;
    check_chr(14'h0C00, 8'h01, 1'b1, "win2_mask");
    ram_cnt = 4'd4;
    check_chr(14'h0C00, 8'h03, 1'b1, "win4_off3");
    check_chr(14'h0800, 8'h02, 1'b1, "win4_off2");
    ram_cnt = 4'd0;

    // CHR inversion
    cpu_write(16'h8000, 8'h80);
    check_chr(14'h1000, 8'h00, 1'b0, "inv_s0");
    check_chr(14'h1C00, 8'h09, 1'b0, "inv_s3");
    check_chr(14'h0000, 8'h0B, 1'b0, "inv_s4");

    // PRG mode 1 and truncation
    cpu_write(16'h8000, 8'h46);
    cpu_write(16'h8001, 8'h15);
    check_prg(16'h8000, 8'h3E, "mode1_slot0");
    check_prg(16'hC000, 8'h15, "mode1_slot2");
    check_prg(16'hA000, 8'h01, "mode1_slot1");
    cpu_write(16'h8000, 8'h06);
    check_prg(16'h8000, 8'h15, "mode0_slot0");
    check_prg(16'hC000, 8'h3E, "mode0_slot2");
    cpu_write(16'h8001, 8'hFF);
    check_prg(16'h8000, 8'h3F, "prg_truncate");

    // IRQ count of 3: fires after the 4th qualified edge
    step(); ppu_addr = '0;
    cpu_write(16'hC000, 8'h03);
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b0, "irq_edge1");
    a12_edge(6); check_irq(1'b0, "irq_edge2");
    a12_edge(9); check_irq(1'b0, "irq_edge3");
    a12_edge(6); check_irq(1'b1, "irq_edge4");
    step(); check_irq(1'b1, "irq_sticky");
    cpu_write(16'hE000, 8'h00);
    check_irq(1'b0, "irq_e000_clear");

    // Short low run is not a qualified edge
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); a12_edge(6); a12_edge(6);
    a12_edge(3); check_irq(1'b0, "short_edge_ignored");
    a12_edge(6); check_irq(1'b1, "edge_after_short");
    cpu_write(16'hE000, 8'h00);

    // Latch 0, new revision: every edge fires
    cpu_write(16'hC000, 8'h00);
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b1, "l0_new_first");
    cpu_write(16'hE000, 8'h00);
    check_irq(1'b0, "l0_new_cleared");
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b1, "l0_new_second");
    cpu_write(16'hE000, 8'h00);

    // Latch 0, old revision: only the edge after $C001 fires
    irq_alt = 1'b1;
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b1, "l0_old_first");
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b0, "l0_old_second");
    cpu_write(16'hE000, 8'h00);
    irq_alt = 1'b0;

    // $E000 commit on the same clock as an irq-setting edge
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    step();
    ppu_addr[12] = 1'b0;
    cpu_addr = 16'hE000; cpu_rw = 1'b0; cpu_m2 = 1'b1;
    repeat (7) step();
    cpu_m2 = 1'b0; ppu_addr[12] = 1'b1;
    step();
    cpu_rw = 1'b1;
    check_irq(1'b0, "e000_beats_edge");
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b1, "edge_after_collision");
    cpu_write(16'hE000, 8'h00);

    // Reset in the middle of a count with irq pending
    cpu_write(16'hC001, 8'h00);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6);
    cpu_write(16'hC000, 8'h05);
    a12_edge(6); check_irq(1'b1, "pending_before_reset");
    mir_h = 1'b0;
    step();
    rst_n = 1'b0;
    check_irq(1'b0, "irq_async_reset");
    step();
    rst_n = 1'b1;
    check_a10(14'h0800, 1'b0, "mir_h0_after_reset");
    check_chr(14'h1000, 8'h04, 1'b0, "r2_after_reset");
    cpu_write(16'hC000, 8'h02);
    cpu_write(16'hE001, 8'h00);
    a12_edge(6); check_irq(1'b0, "post_reset_edge1");
    a12_edge(6); check_irq(1'b0, "post_reset_edge2");
    a12_edge(6); check_irq(1'b1, "post_reset_edge3");

    repeat (2) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
